// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fetch_stage_pkg;

  localparam int INST_W = 16;
  localparam int ADDR_W = 16;

  // Byte increment between consecutive 16-bit instructions.
  localparam logic [ADDR_W-1:0] PC_INC = 16'd2;

  // RUN: may issue; WAIT: request outstanding; DRAIN: outstanding response
  // will be discarded; HALTED: idle until reset.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

  // One buffered fetch result: the address it came from and the instruction.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's memory, control and IF/ID signals.
// Latency: n/a (wiring only).
// Backpressure: imem_req held until imem_ack; stall holds IF/ID.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  // Instruction memory handshake
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_data;

  // Control from hazard unit / branch logic
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;

  // IF/ID pipeline register
  logic              if_id_valid;
  logic [INST_W-1:0] if_id_inst;
  logic [ADDR_W-1:0] if_id_pc;
  logic [ADDR_W-1:0] if_id_pc_next;
  logic              halted;

  // Fetch stage side
  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_data,
    input  stall, redirect, redirect_pc, halt,
    output if_id_valid, if_id_inst, if_id_pc, if_id_pc_next, halted
  );

  // Memory / decode / hazard side
  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_data,
    output stall, redirect, redirect_pc, halt,
    input  if_id_valid, if_id_inst, if_id_pc, if_id_pc_next, halted
  );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Small circular FIFO of fetch entries with push, pop and flush.
// Latency: push visible at head one cycle later; head is read combinationally.
// Backpressure: pop on empty ignored; push on full accepted only with a pop.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  fetch_entry_t     i_push_dat,
  input  logic             i_pop,
  input  logic             i_flush,
  output fetch_entry_t     o_head_dat,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CNT_W'(DEPTH));
  assign o_count    = r_count;
  assign o_head_dat = r_mem[r_rd_ptr];

  // A full FIFO can still take a push when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointers and occupancy; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Entry storage needs no reset: occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, requests imem, buffers results, drives IF/ID.
// Latency: same-cycle ack in cycle N reaches IF/ID at the edge ending N+1.
// Backpressure: stall holds IF/ID; new requests only while FIFO space is reserved.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = fetch_stage_pkg::PC_INC,
  parameter int          DEPTH    = 2
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master fe_if
);
  import fetch_stage_pkg::ADDR_W;
  import fetch_stage_pkg::INST_W;
  import fetch_stage_pkg::fetch_state_t;
  import fetch_stage_pkg::fetch_entry_t;
  import fetch_stage_pkg::ST_RUN;
  import fetch_stage_pkg::ST_WAIT;
  import fetch_stage_pkg::ST_DRAIN;
  import fetch_stage_pkg::ST_HALTED;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_req_addr;
  logic [ADDR_W-1:0] w_req_addr_nxt;
  logic [ADDR_W-1:0] w_addr;
  logic              w_req;
  logic              w_push;
  logic              w_pop;
  logic              w_redir;
  logic              w_issue_ok;

  logic              r_if_id_valid;
  logic [INST_W-1:0] r_if_id_inst;
  logic [ADDR_W-1:0] r_if_id_pc;

  fetch_entry_t      w_push_dat;
  fetch_entry_t      w_head_dat;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;

  // Halt (and an already-halted stage) masks redirects completely.
  assign w_redir = fe_if.redirect && !fe_if.halt && (r_state != ST_HALTED);
  // A redirect flushes instead of popping.
  assign w_pop   = !fe_if.stall && !w_redir && !w_fifo_empty;
  // Space is reserved at issue time so the response can always be pushed.
  assign w_issue_ok = !fe_if.halt && ((w_fifo_count < CNT_W'(DEPTH)) || w_pop);

  assign w_push_dat.pc   = w_addr;
  assign w_push_dat.inst = fe_if.imem_data;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push && (!w_fifo_full || w_pop)),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_flush    (w_redir),
    .o_head_dat (w_head_dat),
    .o_count    (w_fifo_count),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  // Next state, request and push decisions; a redirect always reloads the PC.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_req_addr_nxt = r_req_addr;
    w_addr         = r_req_addr;
    w_req          = 1'b0;
    w_push         = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_addr = r_pc;
        if (w_issue_ok) begin
          w_req = 1'b1;
          if (fe_if.imem_ack) begin
            w_push   = !w_redir;
            w_pc_nxt = r_pc + PC_INC;
          end else begin
            w_req_addr_nxt = r_pc;
            w_state_nxt    = w_redir ? ST_DRAIN : ST_WAIT;
          end
        end else if (fe_if.halt) begin
          w_state_nxt = ST_HALTED;
        end
      end
      ST_WAIT: begin
        w_req = 1'b1;
        if (fe_if.imem_ack) begin
          if (w_redir) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_push      = 1'b1;
            w_pc_nxt    = r_pc + PC_INC;
            w_state_nxt = fe_if.halt ? ST_HALTED : ST_RUN;
          end
        end else if (w_redir) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_req = 1'b1;
        if (fe_if.imem_ack) w_state_nxt = fe_if.halt ? ST_HALTED : ST_RUN;
      end
      default: ;
    endcase
    if (w_redir) w_pc_nxt = fe_if.redirect_pc;
  end

  // Fetch state, PC and the address of the outstanding request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_req_addr <= w_req_addr_nxt;
    end
  end

  // IF/ID register: squash on redirect, hold on stall, otherwise pop or bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_if_id_valid <= 1'b0;
      r_if_id_inst  <= '0;
      r_if_id_pc    <= '0;
    end else if (w_redir) begin
      r_if_id_valid <= 1'b0;
    end else if (!fe_if.stall) begin
      r_if_id_valid <= w_pop;
      if (w_pop) begin
        r_if_id_inst <= w_head_dat.inst;
        r_if_id_pc   <= w_head_dat.pc;
      end
    end
  end

  // No request while reset is held, so a pending ack is never consumed.
  assign fe_if.imem_req      = w_req && rst;
  assign fe_if.imem_addr     = w_addr;
  assign fe_if.halted        = (r_state == ST_HALTED);
  assign fe_if.if_id_valid   = r_if_id_valid;
  assign fe_if.if_id_inst    = r_if_id_inst;
  assign fe_if.if_id_pc      = r_if_id_pc;
  // Forced to zero while reset is held so every IF/ID output reads 0 then.
  assign fe_if.if_id_pc_next = rst ? (r_if_id_pc + PC_INC) : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based reference model.
// Memory model answers with a random latency; stall/redirect/halt are random.
// All comparisons go through check_val; one summary line at the end.
module tb_fetch_stage;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if fe_if();

  fetch_stage #(
    .RESET_PC (16'h0000),
    .PC_INC   (16'd2),
    .DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .fe_if (fe_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched {pc, inst}, one outstanding-request
  // flag with a discard marker, the fetch PC and the IF/ID contents.
  typedef struct {
    logic [15:0] pc;
    logic [15:0] inst;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_pc, m_oaddr, m_ifpc, m_ifinst;
  bit          m_outst, m_drop, m_halted, m_ifv;
  bit          mem_pend;
  int          mem_cnt;

  task automatic model_reset();
    q.delete();
    m_pc = 16'h0000; m_oaddr = 16'h0000;
    m_ifpc = 16'h0000; m_ifinst = 16'h0000;
    m_outst = 0; m_drop = 0; m_halted = 0; m_ifv = 0;
    mem_pend = 0; mem_cnt = 0;
  endtask

  // Hold reset for one edge, check the reset outputs, then release.
  task automatic do_reset();
    rst = 1'b0;
    fe_if.imem_ack = 1'b0; fe_if.imem_data = 16'h0000;
    fe_if.stall = 1'b0; fe_if.redirect = 1'b0;
    fe_if.redirect_pc = 16'h0000; fe_if.halt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check_val("rst_req",     16'(fe_if.imem_req), 16'h0);
    check_val("rst_valid",   16'(fe_if.if_id_valid), 16'h0);
    check_val("rst_pc",      fe_if.if_id_pc, 16'h0);
    check_val("rst_inst",    fe_if.if_id_inst, 16'h0);
    check_val("rst_pc_next", fe_if.if_id_pc_next, 16'h0);
    check_val("rst_halted",  16'(fe_if.halted), 16'h0);
    rst = 1'b1;
  endtask

  // One clock cycle: drive inputs at the falling edge, check, advance model.
  task automatic do_cycle(input bit s_stall, input bit s_redir, input logic [15:0] s_rpc,
                          input bit s_halt, input int minlat, input int maxlat);
    bit          redir_eff, pop_now, exp_req, ack;
    logic [15:0] exp_addr, data;
    ent_t        e;

    fe_if.stall       = s_stall;
    fe_if.redirect    = s_redir;
    fe_if.redirect_pc = s_rpc;
    fe_if.halt        = s_halt;

    redir_eff = s_redir && !s_halt && !m_halted;
    pop_now   = !s_stall && !redir_eff && (q.size() > 0);
    exp_req   = !m_halted && (m_outst || (!s_halt && ((q.size() < DEPTH) || pop_now)));
    exp_addr  = m_outst ? m_oaddr : m_pc;

    // Memory: pick a latency when a request first appears, ack when it expires.
    ack  = 0;
    data = 16'($urandom);
    if (exp_req) begin
      if (!mem_pend) begin
        mem_pend = 1;
        mem_cnt  = $urandom_range(maxlat, minlat);
      end
      if (mem_cnt == 0) begin
        ack = 1;
        mem_pend = 0;
      end else begin
        mem_cnt--;
      end
    end
    fe_if.imem_ack  = ack;
    fe_if.imem_data = data;

    #1;
    check_val("imem_req", 16'(fe_if.imem_req), 16'(exp_req));
    if (exp_req) check_val("imem_addr", fe_if.imem_addr, exp_addr);
    check_val("halted",        16'(fe_if.halted), 16'(m_halted));
    check_val("if_id_valid",   16'(fe_if.if_id_valid), 16'(m_ifv));
    check_val("if_id_pc",      fe_if.if_id_pc, m_ifpc);
    check_val("if_id_inst",    fe_if.if_id_inst, m_ifinst);
    check_val("if_id_pc_next", fe_if.if_id_pc_next, m_ifpc + 16'd2);

    // IF/ID consumes the oldest buffered fetch before this cycle's result lands.
    if (redir_eff) begin
      q.delete();
      m_ifv = 0;
    end else if (!s_stall) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        m_ifv = 1; m_ifpc = e.pc; m_ifinst = e.inst;
      end else begin
        m_ifv = 0;
      end
    end
    if (exp_req && ack) begin
      if (!(m_drop || redir_eff)) begin
        e.pc = exp_addr; e.inst = data;
        q.push_back(e);
        m_pc = m_pc + 16'd2;
      end
      m_outst = 0;
      m_drop  = 0;
    end else if (exp_req) begin
      m_outst = 1;
      m_oaddr = exp_addr;
      if (redir_eff) m_drop = 1;
    end
    if (redir_eff) m_pc = s_rpc;
    if (!m_halted && s_halt && !m_outst) m_halted = 1;

    @(posedge clk);
    @(negedge clk);
  endtask

  // One scenario from reset; halt is sticky from halt_at; optional forced redirect.
  task automatic run_phase(input int n, input int stall_pct, input int redir_pct,
                           input int halt_at, input int minlat, input int maxlat,
                           input int force_at, input logic [15:0] force_pc);
    bit          s_stall, s_redir, s_halt;
    logic [15:0] s_rpc;
    do_reset();
    for (int i = 0; i < n; i++) begin
      s_stall = ($urandom_range(99, 0) < stall_pct);
      s_redir = ($urandom_range(99, 0) < redir_pct);
      s_rpc   = 16'($urandom) & 16'hFFFE;
      s_halt  = (halt_at >= 0) && (i >= halt_at);
      if (i == force_at) begin
        s_redir = 1;
        s_rpc   = force_pc;
      end
      do_cycle(s_stall, s_redir, s_rpc, s_halt, minlat, maxlat);
    end
  endtask

  initial begin
    // Combinational memory, free-running stream.
    run_phase(40, 0, 0, -1, 0, 0, -1, 16'h0000);
    // Heavy stalls with combinational memory.
    run_phase(60, 40, 0, -1, 0, 0, -1, 16'h0000);
    // 3-cycle memory, redirect to 0x0100 one cycle into WAIT.
    run_phase(30, 0, 0, -1, 3, 3, 1, 16'h0100);
    // Random latency with stalls and redirects (includes stall+redirect cycles).
    run_phase(120, 25, 10, -1, 0, 3, -1, 16'h0000);
    // Halt with a 3-cycle request outstanding; later redirects must be ignored.
    run_phase(30, 20, 30, 1, 3, 3, -1, 16'h0000);
    // Halt while draining a redirected request.
    run_phase(30, 0, 0, 2, 3, 3, 1, 16'h0200);
    // PC wrap: redirect near the top of the address space.
    run_phase(20, 0, 0, -1, 0, 0, 0, 16'hFFF8);
    // Wrap again under stalls and latency.
    run_phase(30, 30, 0, -1, 0, 2, 0, 16'hFFFA);
    // Long mixed run ending in halt.
    run_phase(200, 25, 8, 150, 0, 2, -1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
